pipeline_hazard_ctrl: RTL

//  Central stall/flush/redirect sequencer for the 5-stage pipeline. Takes hazard
//  and control-flow events from ID/EX plus IRQ and memory-busy, and drives PC

---
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int EXC_DRAIN = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_exception,
  input  logic             ex_branch_tk,
  input  logic             irq,
  input  logic             pc31,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic [2:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             epc_write,
  output logic             irq_ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);
  localparam int DW = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(EXC_DRAIN - 1);
  typedef enum logic [1:0] {RUN = 2'd0, EXC_DRN = 2'd1, EXC_REDIR = 2'd2} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] drain_cnt, drain_d;
  logic irq_pend, cause_irq, cause_d, load_use, trap;
  assign load_use = ex_mem_read && ex_rt != 5'd0 &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  assign trap = id_exception || (irq_pend && !pc31);
  assign state = state_q;
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 3'd0;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    epc_write   = 1'b0;
    irq_ack     = 1'b0;
    state_d     = state_q;
    drain_d     = drain_cnt;
    cause_d     = cause_irq;
    if (!reset_b) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_tk) begin
            pc_sel      = 3'd1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (trap) begin
            epc_write   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            cause_d     = !id_exception;
            drain_d     = DRAIN_INIT;
            state_d     = EXC_DRN;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_jr || id_jump) begin
            pc_sel      = id_jr ? 3'd3 : 3'd2;
            if_id_flush = 1'b1;
          end
        end
        EXC_DRN: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          drain_d     = (drain_cnt == '0) ? drain_cnt : drain_cnt - 1'b1;
          state_d     = (drain_cnt == '0) ? EXC_REDIR : EXC_DRN;
        end
        EXC_REDIR: begin
          pc_sel      = cause_irq ? 3'd5 : 3'd4;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          irq_ack     = cause_irq;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= RUN;
      drain_cnt   <= '0;
      irq_pend    <= 1'b0;
      cause_irq   <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt   <= drain_d;
      cause_irq   <= cause_d;
      irq_pend    <= (irq_pend | irq) & ~irq_ack;
      stall_count <= (!pc_write && !(&stall_count)) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule
